// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI interconnect arbiters (m2s and s2m paths).
package axi_arb_pkg;

  localparam int LOCK_XACT = 1;
  localparam int LOCK_NONE = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after `last`, wrapping modulo N.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  // Lower half keeps only requesters above `last`; upper half is the full
  // vector, so the lowest set bit overall is the next one in rotation order.
  logic [2*N-1:0] w_dbl;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dbl
      assign w_dbl[gi]   = req[gi] & (IDX_W'(gi) > last);
      assign w_dbl[N+gi] = req[gi];
    end
  endgenerate

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        win_vld = 1'b1;
        win_idx = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/round_robin_arb_n.sv
// N-way round-robin arbiter with registered one-hot grant and optional
// transaction lock (grant held from award until `done`).
module round_robin_arb_n
  import axi_arb_pkg::*;
#(
  parameter int N     = 3,
  parameter int LOCK  = LOCK_XACT,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_last;
  logic [N-1:0]     r_gnt;
  logic             r_gnt_vld;
  logic [IDX_W-1:0] r_gnt_idx;

  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_vld;
  logic [N-1:0]     w_win_onehot;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req),
    .last    (r_last),
    .win_idx (w_win_idx),
    .win_vld (w_win_vld)
  );

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign w_win_onehot[gi] = w_win_vld & (w_win_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last    <= IDX_W'(N - 1);
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= '0;
    end else if (LOCK == LOCK_XACT) begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld) begin
            r_gnt     <= w_win_onehot;
            r_gnt_vld <= 1'b1;
            r_gnt_idx <= w_win_idx;
            r_last    <= w_win_idx;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Request changes are ignored until the holder signals done.
          if (done) begin
            if (w_win_vld) begin
              r_gnt     <= w_win_onehot;
              r_gnt_idx <= w_win_idx;
              r_last    <= w_win_idx;
            end else begin
              r_gnt     <= '0;
              r_gnt_vld <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      r_gnt     <= w_win_onehot;
      r_gnt_vld <= w_win_vld;
      if (w_win_vld) begin
        r_gnt_idx <= w_win_idx;
        r_last    <= w_win_idx;
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_vld = r_gnt_vld;
  assign gnt_idx = r_gnt_idx;

endmodule

// File: tb/tb_round_robin_arb_n.sv
// Directed bench: locked 3-way arbiter via a vector table, unlocked 5-way by hand.
module tb_round_robin_arb_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst3, done3;
  logic [2:0] req3, gnt3;
  logic       vld3;
  logic [1:0] idx3;

  logic       rst5, done5;
  logic [4:0] req5, gnt5;
  logic       vld5;
  logic [2:0] idx5;

  int checks   = 0;
  int failures = 0;

  round_robin_arb_n #(.N(3), .LOCK(1)) dut3 (
    .clk     (clk),
    .rst     (rst3),
    .req     (req3),
    .done    (done3),
    .gnt     (gnt3),
    .gnt_vld (vld3),
    .gnt_idx (idx3)
  );

  round_robin_arb_n #(.N(5), .LOCK(0)) dut5 (
    .clk     (clk),
    .rst     (rst5),
    .req     (req5),
    .done    (done5),
    .gnt     (gnt5),
    .gnt_vld (vld5),
    .gnt_idx (idx5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       done;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] idx;
    logic       vld;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  initial begin
    // rst, done, req, expected gnt, idx, vld (outputs after the edge)
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0};
    // all requesting, done every 3rd cycle: rotation 0,1,2,0
    vecs[1]  = '{1'b0, 1'b0, 3'b111, 3'b001, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 3'b111, 3'b001, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 3'b111, 3'b001, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 3'b111, 3'b010, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 3'b111, 3'b010, 2'd1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'b111, 3'b010, 2'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 3'b111, 3'b100, 2'd2, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 3'b111, 3'b100, 2'd2, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 3'b111, 3'b100, 2'd2, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 3'b111, 3'b001, 2'd0, 1'b1};
    // done with no requesters -> idle, idx holds; done in idle ignored
    vecs[11] = '{1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'b000, 3'b000, 2'd0, 1'b0};
    // reset, sole requester 2, re-granted to itself on done
    vecs[13] = '{1'b1, 1'b0, 3'b000, 3'b000, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 3'b100, 3'b100, 2'd2, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 3'b100, 3'b100, 2'd2, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 3'b010, 3'b100, 2'd2, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 3'b010, 3'b010, 2'd1, 1'b1};
    // master 1 drops req while busy: grant held until done
    vecs[18] = '{1'b0, 1'b0, 3'b000, 3'b010, 2'd1, 1'b1};
    vecs[19] = '{1'b0, 1'b1, 3'b000, 3'b000, 2'd1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 3'b010, 3'b010, 2'd1, 1'b1};
    // rst together with done while busy: rst wins, then favour req[0]
    vecs[21] = '{1'b1, 1'b1, 3'b111, 3'b000, 2'd0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 3'b111, 3'b001, 2'd0, 1'b1};
    // handover with partial request patterns
    vecs[23] = '{1'b0, 1'b1, 3'b110, 3'b010, 2'd1, 1'b1};
    vecs[24] = '{1'b0, 1'b1, 3'b101, 3'b100, 2'd2, 1'b1};
    vecs[25] = '{1'b0, 1'b1, 3'b011, 3'b001, 2'd0, 1'b1};
    vecs[26] = '{1'b0, 1'b1, 3'b011, 3'b010, 2'd1, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 3'b101, 3'b010, 2'd1, 1'b1};
  end

  initial begin
    int exp_i;
    rst3 = 1'b1; done3 = 1'b0; req3 = '0;
    rst5 = 1'b1; done5 = 1'b0; req5 = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst3  = vecs[i].rst;
      done3 = vecs[i].done;
      req3  = vecs[i].req;
      @(posedge clk);
      #1;
      $display("n3 vec %0d rst=%b done=%b req=%b -> gnt=%b idx=%0d vld=%b",
               i, vecs[i].rst, vecs[i].done, vecs[i].req, gnt3, idx3, vld3);
      chk($sformatf("n3_gnt_v%0d", i), 32'(gnt3), 32'(vecs[i].gnt));
      chk($sformatf("n3_idx_v%0d", i), 32'(idx3), 32'(vecs[i].idx));
      chk($sformatf("n3_vld_v%0d", i), 32'(vld3), 32'(vecs[i].vld));
    end

    // N=5 unlocked: reset state
    @(negedge clk);
    rst5 = 1'b1; req5 = 5'b00000; done5 = 1'b0;
    @(posedge clk); #1;
    $display("n5 reset -> gnt=%b idx=%0d vld=%b", gnt5, idx5, vld5);
    chk("n5_rst_gnt", 32'(gnt5), 32'd0);
    chk("n5_rst_vld", 32'(vld5), 32'd0);
    chk("n5_rst_idx", 32'(idx5), 32'd0);

    // steady 10001 alternates 0,4 every cycle; done is ignored
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst5 = 1'b0; req5 = 5'b10001; done5 = k[0];
      @(posedge clk); #1;
      exp_i = (k % 2 == 0) ? 0 : 4;
      $display("n5 alt %0d req=%b -> gnt=%b idx=%0d vld=%b", k, req5, gnt5, idx5, vld5);
      chk($sformatf("n5_alt_idx%0d", k), 32'(idx5), 32'(exp_i));
      chk($sformatf("n5_alt_gnt%0d", k), 32'(gnt5), 32'(1) << exp_i);
      chk($sformatf("n5_alt_vld%0d", k), 32'(vld5), 32'd1);
    end

    // no requesters: grant clears, index holds last value
    @(negedge clk);
    req5 = 5'b00000;
    @(posedge clk); #1;
    $display("n5 idle req=%b -> gnt=%b idx=%0d vld=%b", req5, gnt5, idx5, vld5);
    chk("n5_idle_gnt", 32'(gnt5), 32'd0);
    chk("n5_idle_vld", 32'(vld5), 32'd0);
    chk("n5_idle_idx", 32'(idx5), 32'd4);

    // 00110 from last=4: 1, 2, 1
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req5 = 5'b00110;
      @(posedge clk); #1;
      exp_i = (k == 1) ? 2 : 1;
      $display("n5 pair %0d req=%b -> gnt=%b idx=%0d vld=%b", k, req5, gnt5, idx5, vld5);
      chk($sformatf("n5_pair_idx%0d", k), 32'(idx5), 32'(exp_i));
      chk($sformatf("n5_pair_gnt%0d", k), 32'(gnt5), 32'(1) << exp_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
